multi_channel_coupling: RTL and testbench
=========================================

// Module: multi_channel_coupling
// PURPOSE
//  N-channel AC/DC/GND input coupling stage for the oscilloscope front end.
//  Sits between the ADC sample formatter and the trigger/capture path.
//  Each channel's DC level is tracked by a first-order leaky integrator
//  (tau = 2^K samples). In AC mode the block outputs the sample minus that level.
//  One shared subtract/accumulate datapath is time-multiplexed across the channels.
// PARAMETERS
//  N_CH  2   number of channels (1..16)
//  W     24  sample width, 2's complement
//  K     8   integrator shift; accumulator width is W+K, signed
// PORTS
//  nReset       in   1        async active-low reset
//  Clk          in   1        system clock (45 MHz)
//  Input        in   N_CH*W   packed samples; ch0 at [W-1:0]
//  In_Valid     in   1        one-cycle strobe: Input is a new sample set
//  Coupling     in   2*N_CH   per-channel mode: 00 DC, 01 AC, 10 GND, 11 = DC
//  Output       out  N_CH*W   packed coupled samples, same packing as Input
//  Out_Valid    out  1        one-cycle strobe: Output updated
//  Busy         out  1        high while channels are being processed
//  Overrun      out  1        sticky: an In_Valid strobe was dropped
//  Clr_Overrun  in   1        synchronous clear of Overrun
// BEHAVIOUR
//  Reset (async, nReset=0):
//   - All accumulators, Output, Out_Valid, Busy, Overrun and the latched modes go to 0.
//   - FSM goes to IDLE. Reset mid-RUN abandons the set; no Out_Valid is issued.
//  FSM: IDLE -> RUN on In_Valid. RUN -> IDLE after channel N_CH-1 is processed.
//   - Acceptance edge: Input and Coupling are latched, ch=0, Busy=1.
//   - RUN: one channel per clock, ch=0..N_CH-1. Each result goes into a shadow register.
//   - Completion edge (the last RUN cycle): shadow register -> Output; Out_Valid=1 for
//     1 cycle; Busy=0.
//   - Latency: Out_Valid goes high N_CH+1 edges after the In_Valid edge.
//   - An In_Valid in the Out_Valid cycle is accepted. Maximum rate: 1 set per N_CH+1 clocks.
//  Per channel c (x = sample, A = acc[c]):
//   - dc = A >>> K (arithmetic shift). d = x - dc, computed in W+1 bits.
//   - A <= A + sign_ext(d). The update happens in every mode, so tracking never stops.
//   - DC mode: out = x.
//   - AC mode: out = sat_W(d), clamped to [-2^(W-1), 2^(W-1)-1].
//   - GND mode: out = 0.
//  Overrun:
//   - In_Valid while Busy=1: the set is dropped, Overrun <= 1, and the current RUN is unaffected.
//   - If a drop and Clr_Overrun happen in the same cycle, set wins.
//  Output holds its value between Out_Valid strobes. Coupling changes take effect at the next acceptance.
// CONFIGURATION
//  COUPLING_FAST_SETTLE_EN (macro):
//   - Defined: per-channel previous mode is stored. When a channel's latched mode
//     changes from non-AC to AC, that sample does A <= x <<< K and out = 0,
//     giving instant settling to the current level.
//   - Undefined: no preload and no stored previous mode. AC output after a mode
//     change reflects the continuously tracked A.
// TESTING (N_CH=2, W=24, K=4 unless stated)
//  1 Reset; Coupling=00_00; In_Valid with ch0=1000, ch1=-5
//    -> Out_Valid 3 clocks later; Output ch0=1000, ch1=-5; Busy high 2 cycles.
//  2 Reset; ch0 AC, constant x=4096, three sets
//    -> ch0 outputs 4096, 3840, 3600 (A = 4096, 7936, 11536).
//  3 ch0 AC; hold x=-8388608 for 2000 sets, then x=8388607
//    -> ch0 = 8388607 (saturated), not a wrapped value.
//  4 In_Valid again 1 clock after acceptance
//    -> second set dropped, Overrun=1, first set's Out_Valid on time.
//    Then Clr_Overrun -> Overrun=0. Drop plus clear in the same cycle -> Overrun=1.
//  5 ch1 GND (10) with x=777 -> ch1 output 0.
//    Switch ch1 to DC -> 777 immediately, with no settling transient.
//  6 DC for 10 sets at x=4096, then AC:
//    - macro on: outputs 0, 0.
//    - macro off: the output continues from tracked A.
//    Assert nReset low mid-RUN -> no Out_Valid and Output=0.

Source files
------------

// File: rtl/multi_channel_coupling.sv
`default_nettype none
// ============================================================================
//  Module   : multi_channel_coupling
//  Purpose  : N-channel AC/DC/GND input coupling with per-channel leaky DC
//             tracking on one time-multiplexed subtract/accumulate datapath.
//             Optional macro: COUPLING_FAST_SETTLE_EN (AC-entry preload).
//  Revision : 1.0 - initial release
// ============================================================================
module multi_channel_coupling #(
    parameter int N_CH = 2,
    parameter int W    = 24,
    parameter int K    = 8
) (
    input  logic                nReset,
    input  logic                Clk,
    input  logic [N_CH*W-1:0]   Input,
    input  logic                In_Valid,
    input  logic [2*N_CH-1:0]   Coupling,
    output logic [N_CH*W-1:0]   Output,
    output logic                Out_Valid,
    output logic                Busy,
    output logic                Overrun,
    input  logic                Clr_Overrun
);

    localparam int              c_CW      = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int              c_AW      = W + K;
    localparam logic [c_CW-1:0] c_LAST    = c_CW'(N_CH - 1);
    localparam logic [1:0]      c_MODE_AC  = 2'b01;
    localparam logic [1:0]      c_MODE_GND = 2'b10;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [c_CW-1:0]        ch_q, ch_d;
    logic [N_CH*W-1:0]      x_q, x_d;
    logic [2*N_CH-1:0]      mode_q, mode_d;
    logic signed [c_AW-1:0] acc_q [N_CH];
    logic signed [c_AW-1:0] acc_d [N_CH];
    logic [N_CH*W-1:0]      shadow_q, shadow_d;
    logic [N_CH*W-1:0]      out_q, out_d;
    logic                   out_valid_q, out_valid_d;
    logic                   overrun_q, overrun_d;

    logic signed [W-1:0]    w_x;
    logic signed [W-1:0]    w_dc;
    logic signed [W:0]      w_d;
    logic [1:0]             w_mode;
    logic signed [c_AW-1:0] w_acc_cur;
    logic signed [c_AW-1:0] w_acc_new;
    logic [W-1:0]           w_sat;
    logic [W-1:0]           w_out;
    logic                   w_drop;

`ifdef COUPLING_FAST_SETTLE_EN
    logic [N_CH-1:0]        prev_ac_q, prev_ac_d;
`endif

    // Shared datapath: operates on whichever channel ch_q selects this cycle.
    always_comb begin
        w_x       = x_q[int'(ch_q)*W +: W];
        w_mode    = mode_q[int'(ch_q)*2 +: 2];
        w_acc_cur = acc_q[ch_q];
        w_dc      = w_acc_cur[c_AW-1:K];
        w_d       = {w_x[W-1], w_x} - {w_dc[W-1], w_dc};
        w_acc_new = w_acc_cur + c_AW'(w_d);
        if (w_d[W] != w_d[W-1]) begin
            w_sat = w_d[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end else begin
            w_sat = w_d[W-1:0];
        end
        case (w_mode)
            c_MODE_AC:  w_out = w_sat;
            c_MODE_GND: w_out = '0;
            default:    w_out = w_x;
        endcase
`ifdef COUPLING_FAST_SETTLE_EN
        prev_ac_d = prev_ac_q;
        if (state_q == S_RUN) begin
            prev_ac_d[ch_q] = (w_mode == c_MODE_AC);
            // Entering AC: jump the integrator straight to the current level.
            if ((w_mode == c_MODE_AC) && !prev_ac_q[ch_q]) begin
                w_acc_new = c_AW'(w_x) <<< K;
                w_out     = '0;
            end
        end
`endif
    end

    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        x_d         = x_q;
        mode_d      = mode_q;
        acc_d       = acc_q;
        shadow_d    = shadow_q;
        out_d       = out_q;
        out_valid_d = 1'b0;
        w_drop      = In_Valid && (state_q == S_RUN);
        overrun_d   = w_drop ? 1'b1 : (Clr_Overrun ? 1'b0 : overrun_q);
        case (state_q)
            S_IDLE: begin
                if (In_Valid) begin
                    x_d     = Input;
                    mode_d  = Coupling;
                    ch_d    = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                acc_d[ch_q]                       = w_acc_new;
                shadow_d[int'(ch_q)*W +: W]       = w_out;
                if (ch_q == c_LAST) begin
                    out_d       = shadow_d;
                    out_valid_d = 1'b1;
                    state_d     = S_IDLE;
                end else begin
                    ch_d = ch_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state_q     <= S_IDLE;
            ch_q        <= '0;
            x_q         <= '0;
            mode_q      <= '0;
            shadow_q    <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                acc_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            x_q         <= x_d;
            mode_q      <= mode_d;
            shadow_q    <= shadow_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
            for (int i = 0; i < N_CH; i++) begin
                acc_q[i] <= acc_d[i];
            end
        end
    end

`ifdef COUPLING_FAST_SETTLE_EN
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            prev_ac_q <= '0;
        end else begin
            prev_ac_q <= prev_ac_d;
        end
    end
`endif

    assign Output    = out_q;
    assign Out_Valid = out_valid_q;
    assign Busy      = (state_q == S_RUN);
    assign Overrun   = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_multi_channel_coupling.sv
`default_nettype none
// ============================================================================
//  Module   : tb_multi_channel_coupling
//  Purpose  : Self-checking bench for multi_channel_coupling (N_CH=2, W=24, K=4)
//             against a behavioural per-channel integrator model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_multi_channel_coupling;

    localparam int     N_CH  = 2;
    localparam int     W     = 24;
    localparam int     K     = 4;
    localparam longint c_MAX = 64'sd8388607;
    localparam longint c_MIN = -64'sd8388608;

    logic                nReset;
    logic                Clk;
    logic [N_CH*W-1:0]   Input;
    logic                In_Valid;
    logic [2*N_CH-1:0]   Coupling;
    logic [N_CH*W-1:0]   Output;
    logic                Out_Valid;
    logic                Busy;
    logic                Overrun;
    logic                Clr_Overrun;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference state: DC level scaled by 2^K, plus last-seen AC flag.
    longint m_acc     [N_CH];
    bit     m_prev_ac [N_CH];

    multi_channel_coupling #(.N_CH(N_CH), .W(W), .K(K)) dut (
        .nReset      (nReset),
        .Clk         (Clk),
        .Input       (Input),
        .In_Valid    (In_Valid),
        .Coupling    (Coupling),
        .Output      (Output),
        .Out_Valid   (Out_Valid),
        .Busy        (Busy),
        .Overrun     (Overrun),
        .Clr_Overrun (Clr_Overrun)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic void model_reset();
        for (int c = 0; c < N_CH; c++) begin
            m_acc[c]     = 0;
            m_prev_ac[c] = 1'b0;
        end
    endfunction

    function automatic logic [W-1:0] model_ch(input int c, input longint x, input logic [1:0] m);
        longint dc, d, r;
        bit     ac;
        ac = (m == 2'b01);
        dc = m_acc[c] >>> K;
        d  = x - dc;
`ifdef COUPLING_FAST_SETTLE_EN
        if (ac && !m_prev_ac[c]) begin
            m_prev_ac[c] = 1'b1;
            m_acc[c]     = x * (64'sd1 <<< K);
            return '0;
        end
        m_prev_ac[c] = ac;
`endif
        m_acc[c] = ((m_acc[c] + d) <<< (64 - W - K)) >>> (64 - W - K);
        if (m == 2'b10)  r = 0;
        else if (ac)     r = (d > c_MAX) ? c_MAX : ((d < c_MIN) ? c_MIN : d);
        else             r = x;
        return W'(r);
    endfunction

    task automatic do_reset();
        nReset      = 1'b0;
        In_Valid    = 1'b0;
        Clr_Overrun = 1'b0;
        Input       = '0;
        Coupling    = '0;
        repeat (2) @(negedge Clk);
        nReset = 1'b1;
        model_reset();
    endtask

    // Drives one set and waits (bounded) for Out_Valid; lat counts negedges
    // from the acceptance edge, busy_n counts Busy-high samples before it.
    task automatic run_set(input bit now, input longint x0, input longint x1,
                           input logic [3:0] mode, output int lat, output int busy_n,
                           output logic [W-1:0] o0, output logic [W-1:0] o1);
        if (!now) @(negedge Clk);
        Input    = {W'(x1), W'(x0)};
        Coupling = mode;
        In_Valid = 1'b1;
        @(negedge Clk);
        In_Valid = 1'b0;
        lat    = 1;
        busy_n = 0;
        while (!Out_Valid && lat < 20) begin
            busy_n += int'(Busy);
            @(negedge Clk);
            lat++;
        end
        o0 = Output[W-1:0];
        o1 = Output[2*W-1:W];
    endtask

    task automatic test_reset();
        logic [W-1:0] o0, o1, e0, e1;
        int lat, busy_n;
        do_reset();
        tests_run++; if (Output !== '0) begin tests_failed++; $display("FAIL reset_output got=%h exp=0", Output); end
        tests_run++; if (Out_Valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid got=%b exp=0", Out_Valid); end
        tests_run++; if (Busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got=%b exp=0", Busy); end
        tests_run++; if (Overrun !== 1'b0) begin tests_failed++; $display("FAIL reset_overrun got=%b exp=0", Overrun); end
        e0 = model_ch(0, 1000, 2'b00);
        e1 = model_ch(1, -5, 2'b00);
        run_set(1'b0, 1000, -5, 4'b0000, lat, busy_n, o0, o1);
        tests_run++; if (lat !== 3) begin tests_failed++; $display("FAIL dc_latency got=%0d exp=3", lat); end
        tests_run++; if (busy_n !== 2) begin tests_failed++; $display("FAIL dc_busy_cycles got=%0d exp=2", busy_n); end
        tests_run++; if (o0 !== e0 || o0 !== W'(1000)) begin tests_failed++; $display("FAIL dc_ch0 got=%0d exp=1000", $signed(o0)); end
        tests_run++; if (o1 !== e1 || o1 !== W'(-5)) begin tests_failed++; $display("FAIL dc_ch1 got=%0d exp=-5", $signed(o1)); end
        @(negedge Clk);
        tests_run++; if (Out_Valid !== 1'b0) begin tests_failed++; $display("FAIL out_valid_pulse got=%b exp=0", Out_Valid); end
        repeat (3) @(negedge Clk);
        tests_run++; if (Output !== {e1, e0}) begin tests_failed++; $display("FAIL output_hold got=%h exp=%h", Output, {e1, e0}); end
    endtask

    task automatic test_ac_tracking();
        logic [W-1:0] o0, o1, e0, e1;
        int lat, busy_n;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            e0 = model_ch(0, 4096, 2'b01);
            e1 = model_ch(1, 0, 2'b00);
            run_set(1'b0, 4096, 0, 4'b0001, lat, busy_n, o0, o1);
            tests_run++; if (o0 !== e0 || lat !== 3) begin tests_failed++; $display("FAIL ac_track[%0d] got=%0d lat=%0d exp=%0d", i, $signed(o0), lat, $signed(e0)); end
        end
    endtask

    task automatic test_saturation();
        logic [W-1:0] o0, o1, e0, e1;
        int lat, busy_n, bad;
        do_reset();
        bad = 0;
        for (int i = 0; i < 2000; i++) begin
            e0 = model_ch(0, c_MIN, 2'b01);
            e1 = model_ch(1, 0, 2'b00);
            run_set(1'b0, c_MIN, 0, 4'b0001, lat, busy_n, o0, o1);
            if (o0 !== e0 || lat !== 3) bad++;
        end
        tests_run++; if (bad !== 0) begin tests_failed++; $display("FAIL sat_settle_sets bad=%0d exp=0", bad); end
        e0 = model_ch(0, c_MAX, 2'b01);
        e1 = model_ch(1, 0, 2'b00);
        run_set(1'b0, c_MAX, 0, 4'b0001, lat, busy_n, o0, o1);
        tests_run++; if (o0 !== e0 || o0 !== W'(c_MAX)) begin tests_failed++; $display("FAIL sat_positive got=%0d exp=%0d", $signed(o0), c_MAX); end
    endtask

    task automatic test_overrun();
        logic [W-1:0] e0, e1;
        int lat, nvalid;
        do_reset();
        @(negedge Clk);
        Input = {W'(200), W'(100)}; Coupling = 4'b0101; In_Valid = 1'b1;
        e0 = model_ch(0, 100, 2'b01);
        e1 = model_ch(1, 200, 2'b01);
        @(negedge Clk);
        Input = {W'(-1), W'(-1)}; Coupling = 4'b0000;
        @(negedge Clk);
        In_Valid = 1'b0;
        lat = 2;
        while (!Out_Valid && lat < 20) begin @(negedge Clk); lat++; end
        tests_run++; if (lat !== 3) begin tests_failed++; $display("FAIL ovr_latency got=%0d exp=3", lat); end
        tests_run++; if (Output !== {e1, e0}) begin tests_failed++; $display("FAIL ovr_first_set got=%h exp=%h", Output, {e1, e0}); end
        tests_run++; if (Overrun !== 1'b1) begin tests_failed++; $display("FAIL ovr_set got=%b exp=1", Overrun); end
        nvalid = 0;
        repeat (5) begin @(negedge Clk); nvalid += int'(Out_Valid); end
        tests_run++; if (nvalid !== 0) begin tests_failed++; $display("FAIL ovr_dropped_run got=%0d exp=0", nvalid); end
        Clr_Overrun = 1'b1;
        @(negedge Clk);
        Clr_Overrun = 1'b0;
        tests_run++; if (Overrun !== 1'b0) begin tests_failed++; $display("FAIL ovr_clear got=%b exp=0", Overrun); end
        Input = {W'(300), W'(-300)}; Coupling = 4'b0001; In_Valid = 1'b1;
        e0 = model_ch(0, -300, 2'b01);
        e1 = model_ch(1, 300, 2'b00);
        @(negedge Clk);
        Clr_Overrun = 1'b1;
        @(negedge Clk);
        In_Valid = 1'b0; Clr_Overrun = 1'b0;
        tests_run++; if (Overrun !== 1'b1) begin tests_failed++; $display("FAIL ovr_set_wins got=%b exp=1", Overrun); end
        lat = 2;
        while (!Out_Valid && lat < 20) begin @(negedge Clk); lat++; end
        tests_run++; if (Output !== {e1, e0} || lat !== 3) begin tests_failed++; $display("FAIL ovr_second_set got=%h lat=%0d exp=%h", Output, lat, {e1, e0}); end
    endtask

    task automatic test_gnd_dc();
        logic [W-1:0] o0, o1, e0, e1;
        int lat, busy_n;
        do_reset();
        e0 = model_ch(0, 5, 2'b00);
        e1 = model_ch(1, 777, 2'b10);
        run_set(1'b0, 5, 777, 4'b1000, lat, busy_n, o0, o1);
        tests_run++; if (o1 !== e1 || o1 !== '0) begin tests_failed++; $display("FAIL gnd_ch1 got=%0d exp=0", $signed(o1)); end
        e0 = model_ch(0, 5, 2'b00);
        e1 = model_ch(1, 777, 2'b11);
        run_set(1'b0, 5, 777, 4'b1100, lat, busy_n, o0, o1);
        tests_run++; if (o1 !== e1 || o1 !== W'(777)) begin tests_failed++; $display("FAIL dc_after_gnd got=%0d exp=777", $signed(o1)); end
    endtask

    task automatic test_dc_to_ac_and_reset();
        logic [W-1:0] o0, o1, e0, e1;
        int lat, busy_n, nvalid;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            e0 = model_ch(0, 4096, 2'b00);
            e1 = model_ch(1, 4096, 2'b00);
            run_set(1'b0, 4096, 4096, 4'b0000, lat, busy_n, o0, o1);
        end
        for (int i = 0; i < 2; i++) begin
            e0 = model_ch(0, 4096, 2'b01);
            e1 = model_ch(1, 4096, 2'b01);
            run_set(1'b0, 4096, 4096, 4'b0101, lat, busy_n, o0, o1);
            tests_run++; if (o0 !== e0 || o1 !== e1) begin tests_failed++; $display("FAIL dc_to_ac[%0d] got=%0d,%0d exp=%0d,%0d", i, $signed(o0), $signed(o1), $signed(e0), $signed(e1)); end
        end
        @(negedge Clk);
        Input = {W'(50), W'(60)}; Coupling = 4'b0000; In_Valid = 1'b1;
        @(negedge Clk);
        In_Valid = 1'b0;
        nReset = 1'b0;
        #1;
        tests_run++; if (Output !== '0 || Busy !== 1'b0 || Out_Valid !== 1'b0) begin tests_failed++; $display("FAIL midrun_reset out=%h busy=%b ov=%b exp=0", Output, Busy, Out_Valid); end
        @(negedge Clk);
        nReset = 1'b1;
        model_reset();
        nvalid = 0;
        repeat (5) begin @(negedge Clk); nvalid += int'(Out_Valid); end
        tests_run++; if (nvalid !== 0 || Output !== '0) begin tests_failed++; $display("FAIL midrun_no_valid got=%0d out=%h exp=0", nvalid, Output); end
    endtask

    task automatic test_back_to_back_random();
        logic [W-1:0] o0, o1, e0, e1, r0, r1;
        logic [3:0]   mode;
        longint       x0, x1;
        int lat, busy_n;
        do_reset();
        for (int i = 0; i < 60; i++) begin
            r0   = W'($urandom);
            r1   = W'($urandom);
            if ($urandom_range(0, 3) == 0) r0 = {r0[W-1], {(W-1){~r0[W-1]}}};
            x0   = longint'($signed(r0));
            x1   = longint'($signed(r1));
            mode = 4'($urandom);
            e0 = model_ch(0, x0, mode[1:0]);
            e1 = model_ch(1, x1, mode[3:2]);
            run_set((i > 0) && ($urandom_range(0, 1) == 1), x0, x1, mode, lat, busy_n, o0, o1);
            tests_run++; if (o0 !== e0 || o1 !== e1 || lat !== 3) begin tests_failed++; $display("FAIL rand[%0d] mode=%b got=%0d,%0d lat=%0d exp=%0d,%0d", i, mode, $signed(o0), $signed(o1), lat, $signed(e0), $signed(e1)); end
        end
        tests_run++; if (Overrun !== 1'b0) begin tests_failed++; $display("FAIL b2b_no_overrun got=%b exp=0", Overrun); end
    endtask

    initial begin
        test_reset();
        test_ac_tracking();
        test_saturation();
        test_overrun();
        test_gnd_dc();
        test_dc_to_ac_and_reset();
        test_back_to_back_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
